// File: rtl/cordic_vectoring.sv
// ============================================================================
// Module   : cordic_vectoring (with cordic_lut)
// Brief    : Iterative CORDIC vectoring engine returning K-scaled magnitude and
//            atan2(y, x) in units of pi/2^32 rad, behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_lut #(
    parameter int INPUT_WIDTH = 5
) (
    input  logic [INPUT_WIDTH-1:0] i_index,
    output logic [31:0]            o_atan
);
    logic [31:0] w_idx;

    // atan(2^-i) expressed in units of pi/2^32 rad
    always_comb begin
        w_idx  = {{(32-INPUT_WIDTH){1'b0}}, i_index};
        o_atan = 32'd0;
        case (w_idx)
            32'd0:  o_atan = 32'd1073741824;
            32'd1:  o_atan = 32'd633866811;
            32'd2:  o_atan = 32'd334917815;
            32'd3:  o_atan = 32'd170009512;
            32'd4:  o_atan = 32'd85334662;
            32'd5:  o_atan = 32'd42708931;
            32'd6:  o_atan = 32'd21359677;
            32'd7:  o_atan = 32'd10680490;
            32'd8:  o_atan = 32'd5340327;
            32'd9:  o_atan = 32'd2670173;
            32'd10: o_atan = 32'd1335088;
            32'd11: o_atan = 32'd667544;
            32'd12: o_atan = 32'd333772;
            32'd13: o_atan = 32'd166886;
            32'd14: o_atan = 32'd83443;
            32'd15: o_atan = 32'd41722;
            32'd16: o_atan = 32'd20861;
            32'd17: o_atan = 32'd10430;
            32'd18: o_atan = 32'd5215;
            32'd19: o_atan = 32'd2608;
            32'd20: o_atan = 32'd1304;
            32'd21: o_atan = 32'd652;
            32'd22: o_atan = 32'd326;
            32'd23: o_atan = 32'd163;
            32'd24: o_atan = 32'd81;
            32'd25: o_atan = 32'd41;
            32'd26: o_atan = 32'd20;
            32'd27: o_atan = 32'd10;
            32'd28: o_atan = 32'd5;
            32'd29: o_atan = 32'd3;
            32'd30: o_atan = 32'd1;
            32'd31: o_atan = 32'd1;
            default: o_atan = 32'd0;
        endcase
    end
endmodule

module cordic_vectoring #(
    parameter int BIT_WIDTH   = 32,
    parameter int ITERATIONS  = 32,
    parameter int INPUT_WIDTH = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] x_in,
    input  logic signed [BIT_WIDTH-1:0] y_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic        [BIT_WIDTH+1:0] mag_out,
    output logic signed [BIT_WIDTH+1:0] angle_out
);
    localparam int                     c_w       = BIT_WIDTH + 2;
    localparam logic [INPUT_WIDTH-1:0] c_last    = INPUT_WIDTH'(ITERATIONS - 1);
    localparam logic signed [c_w-1:0]  c_half_pi = {{(c_w-32){1'b0}}, 32'h8000_0000};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state, w_state_nxt;
    logic [INPUT_WIDTH-1:0]  r_cnt;
    logic signed [c_w-1:0]   r_x, r_y, r_z;
    logic                    r_zero;
    logic [31:0]             w_atan;
    logic signed [c_w-1:0]   w_atan_ext;
    logic signed [c_w-1:0]   w_xe, w_ye, w_x0, w_y0, w_z0;
    logic signed [c_w-1:0]   w_xs, w_ys, w_x_nxt, w_y_nxt, w_z_nxt;

    cordic_lut #(.INPUT_WIDTH(INPUT_WIDTH)) u_lut (
        .i_index (r_cnt),
        .o_atan  (w_atan)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = (r_state == S_IDLE);
        out_valid   = (r_state == S_DONE);
        case (r_state)
            S_IDLE:  if (in_valid)         w_state_nxt = S_ITER;
            S_ITER:  if (r_cnt == c_last)  w_state_nxt = S_DONE;
            S_DONE:  if (out_ready)        w_state_nxt = S_IDLE;
            default:                       w_state_nxt = S_IDLE;
        endcase
    end

    // Pre-rotation folds the left half-plane into x >= 0 by a +/-90 degree turn
    always_comb begin
        w_xe = {{2{x_in[BIT_WIDTH-1]}}, x_in};
        w_ye = {{2{y_in[BIT_WIDTH-1]}}, y_in};
        w_x0 = w_xe;
        w_y0 = w_ye;
        w_z0 = '0;
        if (w_xe[c_w-1]) begin
            if (!w_ye[c_w-1]) begin
                w_x0 = w_ye;
                w_y0 = -w_xe;
                w_z0 = c_half_pi;
            end else begin
                w_x0 = -w_ye;
                w_y0 = w_xe;
                w_z0 = -c_half_pi;
            end
        end
    end

    always_comb begin
        w_xs       = r_x >>> r_cnt;
        w_ys       = r_y >>> r_cnt;
        w_atan_ext = {{(c_w-32){1'b0}}, w_atan};
        if (!r_y[c_w-1]) begin
            w_x_nxt = r_x + w_ys;
            w_y_nxt = r_y - w_xs;
            w_z_nxt = r_z + w_atan_ext;
        end else begin
            w_x_nxt = r_x - w_ys;
            w_y_nxt = r_y + w_xs;
            w_z_nxt = r_z - w_atan_ext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_zero    <= 1'b0;
            mag_out   <= '0;
            angle_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_x    <= w_x0;
                        r_y    <= w_y0;
                        r_z    <= w_z0;
                        r_zero <= (x_in == '0) && (y_in == '0);
                        r_cnt  <= '0;
                    end
                end
                S_ITER: begin
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    r_z   <= w_z_nxt;
                    r_cnt <= r_cnt + INPUT_WIDTH'(1);
                    if (r_cnt == c_last) begin
                        mag_out   <= r_zero ? '0 : w_x_nxt;
                        angle_out <= r_zero ? '0 : w_z_nxt;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
// ============================================================================
// Module   : tb_cordic_vectoring
// Brief    : Self-checking bench for cordic_vectoring against a real-valued
//            atan2/hypot reference.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_vectoring;
    localparam int  c_iter = 32;
    localparam real c_pi   = 3.14159265358979323846;
    localparam real c_k    = 1.6467602581;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] x_in = '0;
    logic signed [31:0] y_in = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic        [33:0] mag_out;
    logic signed [33:0] angle_out;

    int n_cmp = 0;
    int n_err = 0;

    cordic_vectoring dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .angle_out (angle_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint act, input longint exp, input longint tol);
        longint d;
        bit     ok;
        n_cmp++;
        d  = act - exp;
        if (d < 0) d = -d;
        ok = (d <= tol);
        assert (ok === 1'b1) else begin
            n_err++;
            $error("FAIL %s: got %0d, want %0d (tol %0d)", tag, act, exp, tol);
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    // Present one vector, check latency and result against the reference
    task automatic run_vec(input string tag, input longint xv, input longint yv,
                           input longint mtol, input longint atol, input bit drain);
        real    xr, yr;
        longint exp_mag, exp_ang;
        int     g, n;
        xr = real'(xv);
        yr = real'(yv);
        exp_mag = longint'(c_k * $sqrt(xr * xr + yr * yr));
        exp_ang = (xv == 0 && yv == 0) ? 64'sd0 : longint'($atan2(yr, xr) * 4294967296.0 / c_pi);
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk({tag, " in_ready"}, longint'(in_ready), 1, 0);
        x_in     = xv[31:0];
        y_in     = yv[31:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk({tag, " busy"}, longint'(in_ready), 0, 0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk({tag, " latency"}, longint'(n), c_iter, 0);
        chk({tag, " mag"}, longint'(mag_out), exp_mag, mtol);
        chk({tag, " angle"}, longint'(angle_out), exp_ang, atol);
        if (drain) take_result();
    endtask

    initial begin
        longint m_hold, a_hold;
        int     t, first, second, g;

        #1 rst_n = 1'b0;
        #1;
        chk("rst in_ready", longint'(in_ready), 1, 0);
        chk("rst out_valid", longint'(out_valid), 0, 0);
        chk("rst mag", longint'(mag_out), 0, 0);
        chk("rst angle", longint'(angle_out), 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        run_vec("pos_axis", 64'sd1073741824, 64'sd0, 64, 64, 1'b1);
        chk("pos_axis const", longint'(mag_out), 64'sd1768195363, 64);

        // Diagonal result held under backpressure
        run_vec("diag_q1", 64'sd1073741824, 64'sd1073741824, 256, 256, 1'b0);
        m_hold = longint'(mag_out);
        a_hold = longint'(angle_out);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("bp out_valid", longint'(out_valid), 1, 0);
            chk("bp in_ready", longint'(in_ready), 0, 0);
            chk("bp mag stable", longint'(mag_out), m_hold, 0);
            chk("bp angle stable", longint'(angle_out), a_hold, 0);
        end
        take_result();
        chk("bp release in_ready", longint'(in_ready), 1, 0);
        chk("bp release out_valid", longint'(out_valid), 0, 0);

        run_vec("diag_q3", -64'sd2147483648, -64'sd2147483648, 256, 256, 1'b1);
        chk("diag_q3 const", longint'(angle_out), -64'sd3221225472, 256);
        run_vec("neg_axis", -64'sd1073741824, 64'sd0, 64, 64, 1'b1);
        chk("neg_axis plus_pi", longint'(angle_out), 64'sd4294967296, 64);
        run_vec("neg_y", 64'sd0, -64'sd1073741824, 64, 64, 1'b1);
        run_vec("pos_y", 64'sd0, 64'sd1073741824, 64, 64, 1'b1);
        run_vec("zero", 64'sd0, 64'sd0, 0, 0, 1'b1);

        for (int i = 0; i < 8; i++) begin
            int rx, ry;
            do begin
                rx = int'($urandom);
                ry = int'($urandom);
            end while ((rx < 268435456 && rx > -268435456) && (ry < 268435456 && ry > -268435456));
            run_vec("random", longint'(rx), longint'(ry), 256, 512, 1'b1);
        end

        // Back-to-back requests with a consumer that is always ready
        x_in      = 32'sd1073741824;
        y_in      = 32'sd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        t = 0;
        first = -1;
        second = -1;
        while (second < 0 && t < 200) begin
            @(negedge clk);
            if (in_ready) begin
                if (first < 0) first = t;
                else           second = t;
            end
            t++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("b2b interval", longint'(second - first), c_iter + 2, 0);
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk);
            #1 g++;
        end
        out_ready = 1'b0;
        chk("b2b drained", longint'(in_ready), 1, 0);

        // Reset part-way through the iterations
        @(negedge clk);
        x_in     = 32'sd1073741824;
        y_in     = 32'sd1073741824;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst mag", longint'(mag_out), 0, 0);
        chk("midrst angle", longint'(angle_out), 0, 0);
        chk("midrst out_valid", longint'(out_valid), 0, 0);
        chk("midrst in_ready", longint'(in_ready), 1, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("postrst in_ready", longint'(in_ready), 1, 0);
        run_vec("after_rst", 64'sd1073741824, 64'sd0, 64, 64, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative, non-pipelined CORDIC engine in vectoring mode: it takes a Cartesian vector (x, y) and returns its CORDIC-scaled magnitude and its angle atan2(y, x). It is the inverse of the rotation-mode sin/cos engine and shares that engine's arctangent table by instantiating `cordic_lut`. It sits between a valid/ready producer and consumer and handles one vector per transaction.

## Interface
- `BIT_WIDTH`, default 32: width of the signed `x_in`/`y_in` operands. The LUT constants are 32-bit, so this is fixed at 32.
- `ITERATIONS`, default 32: number of micro-rotations, from 1 to 32 (the LUT depth).
- `INPUT_WIDTH`, default 5: width of the LUT index and the iteration counter.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input vector is valid.
- `in_ready`  out  1: engine can accept a vector.
- `x_in`, `y_in`  in  BIT_WIDTH: signed two's-complement operands.
- `out_valid`  out  1: result is valid.
- `out_ready`  in  1: consumer takes the result.
- `mag_out`  out  BIT_WIDTH+2: unsigned magnitude, scaled by K ≈ 1.6467602581.
- `angle_out`  out  BIT_WIDTH+2: signed angle. LSB = π/2^32 rad, so 2^30 = π/4 and ±2^32 = ±π.

## Operation
- **FSM states:** IDLE, ITER, DONE.
- **`in_ready`:** equals (state == IDLE). It is 1 while `rst_n` is low, but no transfer can complete during reset because the flops are held.
- **Accept:** occurs when `in_valid && in_ready` on a clock edge.
  - Pre-rotation is applied, then the state moves to ITER with cnt = 0.
  - Internal `x`, `y`, `z` registers are BIT_WIDTH+2 bits signed. Inputs are sign-extended before any negation.
  - If x_in ≥ 0: x = x_in, y = y_in, z = 0.
  - If x_in < 0 and y_in ≥ 0: x = y_in, y = −x_in, z = +2^31.
  - If x_in < 0 and y_in < 0: x = −y_in, y = x_in, z = −2^31.
  - A zero flag is latched when x_in == 0 and y_in == 0.
- **ITER, step i = cnt:** all updates use the old values of x and y. `>>>` is an arithmetic shift. `atan[i]` is the `cordic_lut` output at index = cnt, zero-extended to BIT_WIDTH+2.
  - If y ≥ 0: x += y>>>i; y −= x>>>i; z += atan[i].
  - If y < 0: x −= y>>>i; y += x>>>i; z −= atan[i].
  - cnt increments each step. The step with cnt == ITERATIONS−1 moves the state to DONE and loads the outputs.
- **Output load:** `mag_out` = x and `angle_out` = z. If the zero flag is set, both are forced to 0.
- **DONE:** `out_valid` = 1. `mag_out` and `angle_out` stay stable until `out_valid && out_ready` on an edge, after which the state returns to IDLE.
- **Ranges:**
  - Since x ≥ 0 after pre-rotation, `mag_out` ≤ 2^31·√2·K < 2^33, so no overflow.
  - `angle_out` lies in [−2^32, +2^32].
  - y_in == 0 with x_in < 0 yields +π, never −π.
- **Output registers:** `mag_out` and `angle_out` change only on the output load.

## Timing
- **Reset:** `rst_n` low asynchronously forces the following; it applies mid-ITER or mid-DONE with no partial result emitted.
  - state = IDLE;
  - cnt = 0;
  - `out_valid` = 0;
  - `mag_out` = 0;
  - `angle_out` = 0;
  - internal x, y, z = 0.
- **Latency:** the accept edge is edge 0. The ITERATIONS-th following edge loads the outputs, and `out_valid` is high after it.
- **Throughput:** `in_ready` is low from the accept edge until the edge that completes the output handshake. The minimum interval between accepts is ITERATIONS+2 cycles.
- **`out_valid`:** never deasserts without a completed handshake, except by reset.
- **Handshake mixing:** there is no combinational path from `in_valid` or `out_ready` to `in_ready` or `out_valid`.
- **`out_ready` outside DONE:** held high in IDLE or ITER, it has no effect.

## Test plan
- **Positive real axis:** (x = 2^30, y = 0) gives `angle_out` = 0 ±64 and `mag_out` = 1768195363 ±64. `out_valid` rises exactly 32 edges after accept.
- **Diagonal cases:**
  - (2^30, 2^30) gives `angle_out` = 1073741824 ±256.
  - (−2^31, −2^31) gives `angle_out` = −3221225472 ±256 and `mag_out` ≈ 5.0013e9 ±256, with no wrap.
- **Quadrant boundaries:**
  - (−2^30, 0) gives `angle_out` = 4294967296 ±64 (+π).
  - (0, −2^30) gives `angle_out` = −2147483648 ±64.
  - (0, 2^30) gives `angle_out` = +2147483648 ±64.
- **Zero vector:** (0, 0) gives `mag_out` = 0 and `angle_out` = 0 exactly, with the same latency as any other input.
- **Backpressure:**
  - Hold `out_ready` = 0 for 10 cycles in DONE: `out_valid` stays 1, the outputs are bit-stable, and `in_ready` stays 0.
  - Assert `out_ready` for one edge: `in_ready` is 1 on the next cycle.
  - Present back-to-back `in_valid`: accepts are ≥ 34 cycles apart.
- **Reset mid-operation:** pulse `rst_n` low at cnt = 15.
  - All outputs read 0 immediately and `in_ready` is 1 after release.
  - A new vector (2^30, 0) then completes normally with correct values.
